// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage defaults and the buffered fetch-entry type.
package cpu_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int DEPTH_DEF = 2;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two prefetch buffer with push, pop, flush, count and head outputs.
module fetch_fifo import cpu_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [AW:0]  count_o,
    output fetch_entry_t head_o
);
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    fetch_entry_t  mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with prefetch buffer and redirect flush.
// Optional stall counter output perf_stall_o when IF_STAGE_PERF_EN is defined.
module if_stage import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
`ifdef IF_STAGE_PERF_EN
    output logic [31:0] perf_stall_o,
`endif
    output logic [31:0] pc_plus4_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d, req_pc_q;
    logic         inflight_q, pop, push;
    logic [AW:0]  count;
    logic [AW+1:0] occ;
    fetch_entry_t head, wr_entry;

    // Reset gates the strobes so they drop without waiting for a clock.
    assign valid_o     = rst_i && !redirect_i && count != '0;
    assign pop         = valid_o && ready_i;
    assign occ         = {1'b0, count} + (AW+2)'(inflight_q) - (AW+2)'(pop);
    assign imem_req_o  = rst_i && start_i && !redirect_i && occ < (AW+2)'(DEPTH);
    assign imem_addr_o = fetch_pc_q;
    assign push        = inflight_q && !redirect_i;
    assign wr_entry    = '{instr: imem_instr_i, pc: req_pc_q};
    assign fetch_pc_d  = redirect_i ? (redirect_pc_i & ~32'd3) :
                         imem_req_o ? fetch_pc_q + 32'd4 : fetch_pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC & ~32'd3;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= fetch_pc_q;
            inflight_q <= imem_req_o;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .count_o (count),
        .head_o  (head)
    );

    assign inst_o     = valid_o ? head.instr : '0;
    assign pc_o       = valid_o ? head.pc : '0;
    assign pc_plus4_o = pc_o + 32'd4;

`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) perf_stall_o <= '0;
        else if (valid_o && !ready_i && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage; memory returns a scrambled copy of the address.
module tb_if_stage;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 0, rst_n = 0, start = 0, redirect = 0, ready = 0;
    logic [31:0] redirect_pc = 0, imem_instr = 0;
    logic imem_req, valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_stall;
`endif
    int tests = 0, fails = 0;
    logic [31:0] exp_q[$];

    if_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .inst_o(inst), .pc_o(pc),
`ifdef IF_STAGE_PERF_EN
        .perf_stall_o(perf_stall),
`endif
        .pc_plus4_o(pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) imem_instr <= imem_req ? mem(imem_addr) : 32'hBAD0_BAD0;

    task automatic do_reset();
        rst_n = 0; start = 0; ready = 0; redirect = 0; redirect_pc = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1; ready = 1;
        @(negedge clk); #1;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", inst); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", pc); end
        tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL reset_pc4 got %h want 4", pc_plus4); end
`ifdef IF_STAGE_PERF_EN
        tests++; if (perf_stall !== 32'h0) begin fails++; $display("FAIL reset_perf got %h want 0", perf_stall); end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        start = 1; ready = 1;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL stream_req0 got %b/%h want 1/0", imem_req, imem_addr); end
        @(negedge clk); #1;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_c1_valid got %b want 0", valid); end
        for (int c = 2; c < 7; c++) begin
            @(negedge clk); #1;
            e = exp_q.pop_front();
            tests++; if (valid !== 1'b1 || pc !== e) begin fails++; $display("FAIL stream_pc c%0d got %b/%h want 1/%h", c, valid, pc, e); end
            tests++; if (inst !== mem(e) || pc_plus4 !== e + 32'd4) begin fails++; $display("FAIL stream_data c%0d got %h/%h want %h/%h", c, inst, pc_plus4, mem(e), e + 32'd4); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        do_reset();
        start = 1; ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests++; if (imem_req !== (c < 2)) begin fails++; $display("FAIL bp_req c%0d got %b want %b", c, imem_req, c < 2); end
            if (c >= 2) begin
                tests++; if (valid !== 1'b1 || pc !== 32'h0) begin fails++; $display("FAIL bp_hold c%0d got %b/%h want 1/0", c, valid, pc); end
            end
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        for (int c = 5; c < 21; c++) begin
            @(negedge clk);
            ready = 1; start = (c <= 8);
            #1;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++; $display("FAIL bp_extra got pc %h want none", pc);
                end else begin
                    e = exp_q.pop_front();
                    tests++; if (pc !== e || inst !== mem(e)) begin fails++; $display("FAIL bp_order got %h/%h want %h/%h", pc, inst, e, mem(e)); end
                end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_lost got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        do_reset();
        start = 1; ready = 1;
        @(negedge clk);
        @(negedge clk); #1;
        tests++; if (valid !== 1'b1 || pc !== 32'h0) begin fails++; $display("FAIL redir_pre got %b/%h want 1/0", valid, pc); end
        @(negedge clk);
        redirect = 1; redirect_pc = 32'h0000_0103;
        #1;
        tests++; if (valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL redir_cycle got %b/%b want 0/0", valid, imem_req); end
        @(negedge clk);
        redirect = 0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL redir_req got %b/%h want 1/100", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
            if (valid) begin
                e = exp_q.pop_front();
                tests++; if (pc !== e || inst !== mem(e)) begin fails++; $display("FAIL redir_pc got %h/%h want %h/%h", pc, inst, e, mem(e)); end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL redir_timeout got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        bit first = 1;
        do_reset();
        start = 1; ready = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        tests++; if (imem_req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL wrap_prio got %b/%b want 0/0", imem_req, valid); end
        @(negedge clk);
        redirect = 0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", imem_req, imem_addr); end
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
            if (valid) begin
                e = exp_q.pop_front();
                tests++; if (pc !== e || inst !== mem(e)) begin fails++; $display("FAIL wrap_pc got %h/%h want %h/%h", pc, inst, e, mem(e)); end
                if (first) begin
                    tests++; if (pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h want 0", pc_plus4); end
                    first = 0;
                end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1; ready = 1;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (valid !== 1'b1 || imem_req !== 1'b1) begin fails++; $display("FAIL arst_pre got %b/%b want 1/1", valid, imem_req); end
        #2 rst_n = 0;
        #1;
        tests++; if (valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin fails++; $display("FAIL arst_async got %b/%b/%h want 0/0/0", valid, imem_req, pc); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin fails++; $display("FAIL arst_req got %b/%h want 1/%h", imem_req, imem_addr, RPC); end
        @(negedge clk); #1;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL arst_stale got %b want 0", valid); end
        @(negedge clk); #1;
        tests++; if (valid !== 1'b1 || pc !== RPC || inst !== mem(RPC)) begin fails++; $display("FAIL arst_first got %b/%h/%h want 1/%h/%h", valid, pc, inst, RPC, mem(RPC)); end
    endtask

`ifdef IF_STAGE_PERF_EN
    task automatic test_perf();
        do_reset();
        start = 1; ready = 0;
        repeat (5) @(negedge clk);
        ready = 1;
        #1;
        tests++; if (perf_stall !== 32'd3) begin fails++; $display("FAIL perf_stall got %0d want 3", perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
`ifdef IF_STAGE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
